// File: rtl/dhcp_server.sv
// dhcp_server: minimal single-lease DHCP server for point-to-point links.
// Parses UDP port-67 payloads and answers DISCOVER with OFFER and REQUEST
// with ACK (requested IP matches offer_ip_i) or NAK. Replies go out as
// broadcasts to port 68 through the shared UDP transmit arbiter.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   rx_data_i/rx_enable_i    received UDP payload byte and its valid strobe
//   dhcp_rx_active_i         high for the whole payload of a port-67 packet
//   server_ip_i              our address (siaddr, option 54)
//   offer_ip_i               the single address leased out
//   subnet_mask_i            option 1 value
//   udp_tx_enable_i          arbiter grant
//   udp_tx_active_i          UDP layer consumes tx_data_o this cycle
//   dhcp_tx_request_o        request to the arbiter
//   tx_data_o, length_o      reply byte and reply payload length
//   client_mac_o             chaddr of the last client that received an ACK
//   lease_granted_o          one-cycle pulse when an ACK finishes sending
//   dhcp_destination_*_o     constant broadcast MAC/IP and port 68
module dhcp_server #(
  parameter logic [31:0] LEASE_TIME = 32'd86400
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_enable_i,
  input  logic        dhcp_rx_active_i,
  input  logic [31:0] server_ip_i,
  input  logic [31:0] offer_ip_i,
  input  logic [31:0] subnet_mask_i,
  input  logic        udp_tx_enable_i,
  input  logic        udp_tx_active_i,
  output logic        dhcp_tx_request_o,
  output logic [7:0]  tx_data_o,
  output logic [15:0] length_o,
  output logic [47:0] client_mac_o,
  output logic        lease_granted_o,
  output logic [47:0] dhcp_destination_mac_o,
  output logic [31:0] dhcp_destination_ip_o,
  output logic [15:0] dhcp_destination_port_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LEN_FULL = 16'd262;
  localparam logic [CNT_W-1:0] LEN_NAK  = 16'd250;
  localparam logic [CNT_W-1:0] MIN_DISC = 16'd243;
  localparam logic [CNT_W-1:0] MIN_REQ  = 16'd249;

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_e;
  typedef enum logic [1:0] {REPLY_OFFER, REPLY_ACK, REPLY_NAK} reply_e;

  tx_state_e        tx_state_q;
  reply_e           reply_q;
  logic [CNT_W-1:0] tx_byte_no_q;
  logic [CNT_W-1:0] rx_byte_no_q;
  logic             drop_q;
  logic             active_q;
  logic             is_request_q;
  logic             ip_match_q;
  logic [31:0]      xid_q;
  logic [47:0]      chaddr_q;

  logic        req_q;
  logic [7:0]  tx_data_q;
  logic [15:0] length_q;
  logic [47:0] client_mac_q;
  logic        lease_q;

  logic       rx_fire, rx_start, rx_fall, busy, drop_now;
  logic       byte_bad, ip_bad, is_nak;
  logic [7:0] tx_byte;

  assign dhcp_tx_request_o       = req_q;
  assign tx_data_o               = tx_data_q;
  assign length_o                = length_q;
  assign client_mac_o            = client_mac_q;
  assign lease_granted_o         = lease_q;
  assign dhcp_destination_mac_o  = 48'hFFFF_FFFF_FFFF;
  assign dhcp_destination_ip_o   = 32'hFFFF_FFFF;
  assign dhcp_destination_port_o = 16'd68;

  assign rx_fire  = rx_enable_i && dhcp_rx_active_i;
  assign rx_start = dhcp_rx_active_i && !active_q;
  assign rx_fall  = active_q && !dhcp_rx_active_i;
  assign busy     = (tx_state_q != TX_IDLE);
  // A packet that starts while a reply is pending is ignored as a whole
  assign drop_now = drop_q || (rx_start && busy);
  assign is_nak   = (reply_q == REPLY_NAK);

  function automatic logic [7:0] pick32(input logic [31:0] w, input logic [1:0] k);
    return 8'(w >> {~k, 3'b000});
  endfunction

  function automatic logic [7:0] pick48(input logic [47:0] w, input logic [2:0] k);
    return 8'(w >> {3'(3'd5 - k), 3'b000});
  endfunction

  // Header field checks on the byte arriving this cycle
  always_comb begin
    byte_bad = 1'b0;
    if (rx_fire) begin
      case (rx_byte_no_q)
        16'd0:   byte_bad = (rx_data_i != 8'h01);
        16'd1:   byte_bad = (rx_data_i != 8'h01);
        16'd2:   byte_bad = (rx_data_i != 8'h06);
        16'd236: byte_bad = (rx_data_i != 8'h63);
        16'd237: byte_bad = (rx_data_i != 8'h82);
        16'd238: byte_bad = (rx_data_i != 8'h53);
        16'd239: byte_bad = (rx_data_i != 8'h63);
        16'd240: byte_bad = (rx_data_i != 8'h35);
        16'd241: byte_bad = (rx_data_i != 8'h01);
        16'd242: byte_bad = (rx_data_i != 8'h01) && (rx_data_i != 8'h03);
        default: byte_bad = 1'b0;
      endcase
    end
  end

  // Requested-IP option (32 04 a.b.c.d) must match offer_ip_i for an ACK
  always_comb begin
    ip_bad = 1'b0;
    if (rx_fire) begin
      case (rx_byte_no_q)
        16'd243: ip_bad = (rx_data_i != 8'h32);
        16'd244: ip_bad = (rx_data_i != 8'h04);
        16'd245: ip_bad = (rx_data_i != offer_ip_i[31:24]);
        16'd246: ip_bad = (rx_data_i != offer_ip_i[23:16]);
        16'd247: ip_bad = (rx_data_i != offer_ip_i[15:8]);
        16'd248: ip_bad = (rx_data_i != offer_ip_i[7:0]);
        default: ip_bad = 1'b0;
      endcase
    end
  end

  // Receive parser: byte counter, drop flag and captured fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_byte_no_q <= '0;
      drop_q       <= 1'b0;
      active_q     <= 1'b0;
      is_request_q <= 1'b0;
      ip_match_q   <= 1'b1;
      xid_q        <= '0;
      chaddr_q     <= '0;
    end else begin
      active_q <= dhcp_rx_active_i;
      if (!dhcp_rx_active_i) begin
        rx_byte_no_q <= '0;
        drop_q       <= 1'b0;
        ip_match_q   <= 1'b1;
      end else begin
        if (rx_start && busy) drop_q <= 1'b1;
        if (rx_fire) begin
          if (rx_byte_no_q != {CNT_W{1'b1}}) rx_byte_no_q <= rx_byte_no_q + 16'd1;
          if (!drop_now) begin
            if (byte_bad) drop_q <= 1'b1;
            if (ip_bad) ip_match_q <= 1'b0;
            if (rx_byte_no_q == 16'd242) is_request_q <= (rx_data_i == 8'h03);
            if (rx_byte_no_q >= 16'd4 && rx_byte_no_q <= 16'd7)
              xid_q <= {xid_q[23:0], rx_data_i};
            if (rx_byte_no_q >= 16'd28 && rx_byte_no_q <= 16'd33)
              chaddr_q <= {chaddr_q[39:0], rx_data_i};
          end
        end
      end
    end
  end

  // Reply byte map, indexed by the byte about to be driven
  always_comb begin
    tx_byte = 8'h00;
    case (tx_byte_no_q) inside
      16'd0:             tx_byte = 8'h02;
      16'd1:             tx_byte = 8'h01;
      16'd2:             tx_byte = 8'h06;
      [16'd4:16'd7]:     tx_byte = pick32(xid_q, 2'(tx_byte_no_q - 16'd4));
      16'd10:            tx_byte = 8'h80;
      [16'd16:16'd19]:   tx_byte = is_nak ? 8'h00 : pick32(offer_ip_i, 2'(tx_byte_no_q - 16'd16));
      [16'd20:16'd23]:   tx_byte = pick32(server_ip_i, 2'(tx_byte_no_q - 16'd20));
      [16'd28:16'd33]:   tx_byte = pick48(chaddr_q, 3'(tx_byte_no_q - 16'd28));
      16'd236:           tx_byte = 8'h63;
      16'd237:           tx_byte = 8'h82;
      16'd238:           tx_byte = 8'h53;
      16'd239:           tx_byte = 8'h63;
      16'd240:           tx_byte = 8'h35;
      16'd241:           tx_byte = 8'h01;
      16'd242:           tx_byte = is_nak ? 8'h06 : (reply_q == REPLY_ACK) ? 8'h05 : 8'h02;
      16'd243:           tx_byte = 8'h36;
      16'd244:           tx_byte = 8'h04;
      [16'd245:16'd248]: tx_byte = pick32(server_ip_i, 2'(tx_byte_no_q - 16'd245));
      16'd249:           tx_byte = is_nak ? 8'hFF : 8'h33;
      16'd250:           tx_byte = is_nak ? 8'h00 : 8'h04;
      [16'd251:16'd254]: tx_byte = is_nak ? 8'h00 : pick32(LEASE_TIME, 2'(tx_byte_no_q - 16'd251));
      16'd255:           tx_byte = is_nak ? 8'h00 : 8'h01;
      16'd256:           tx_byte = is_nak ? 8'h00 : 8'h04;
      [16'd257:16'd260]: tx_byte = is_nak ? 8'h00 : pick32(subnet_mask_i, 2'(tx_byte_no_q - 16'd257));
      16'd261:           tx_byte = is_nak ? 8'h00 : 8'hFF;
      default:           tx_byte = 8'h00;
    endcase
  end

  // Transmit FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q   <= TX_IDLE;
      reply_q      <= REPLY_OFFER;
      tx_byte_no_q <= '0;
      req_q        <= 1'b0;
      tx_data_q    <= '0;
      length_q     <= '0;
      client_mac_q <= '0;
      lease_q      <= 1'b0;
    end else begin
      lease_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (rx_fall && !drop_q &&
              ((!is_request_q && rx_byte_no_q >= MIN_DISC) ||
               ( is_request_q && rx_byte_no_q >= MIN_REQ))) begin
            reply_q    <= !is_request_q ? REPLY_OFFER : (ip_match_q ? REPLY_ACK : REPLY_NAK);
            tx_state_q <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          length_q <= is_nak ? LEN_NAK : LEN_FULL;
          req_q    <= 1'b1;
          if (udp_tx_enable_i && req_q) begin
            tx_data_q    <= 8'h02;
            tx_byte_no_q <= 16'd1;
            tx_state_q   <= TX_SEND;
          end
        end
        TX_SEND: begin
          // Finishing also needs an active cycle: the last byte must be consumed
          if (udp_tx_active_i) begin
            if (tx_byte_no_q == length_q) begin
              req_q        <= 1'b0;
              tx_byte_no_q <= '0;
              tx_state_q   <= TX_IDLE;
              if (reply_q == REPLY_ACK) begin
                client_mac_q <= chaddr_q;
                lease_q      <= 1'b1;
              end
            end else begin
              tx_data_q    <= tx_byte;
              tx_byte_no_q <= tx_byte_no_q + 16'd1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dhcp_server.sv
// Directed testbench for dhcp_server: OFFER/ACK/NAK replies, rejected
// packets, stalled transmit with a colliding DISCOVER, and reset abort.
module tb_dhcp_server;

  localparam logic [31:0] SERVER_IP = 32'hC0A8_0001;
  localparam logic [31:0] OFFER_IP  = 32'hC0A8_0064;
  localparam logic [31:0] MASK      = 32'hFFFF_FF00;
  localparam logic [31:0] OTHER_IP  = 32'hC0A8_0065;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_enable, dhcp_rx_active;
  logic        udp_tx_enable, udp_tx_active;
  logic        dhcp_tx_request_o, lease_granted_o;
  logic [7:0]  tx_data_o;
  logic [15:0] length_o, dest_port;
  logic [47:0] client_mac_o, dest_mac;
  logic [31:0] dest_ip;

  always #5 clk = ~clk;

  dhcp_server dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_data_i(rx_data), .rx_enable_i(rx_enable), .dhcp_rx_active_i(dhcp_rx_active),
    .server_ip_i(SERVER_IP), .offer_ip_i(OFFER_IP), .subnet_mask_i(MASK),
    .udp_tx_enable_i(udp_tx_enable), .udp_tx_active_i(udp_tx_active),
    .dhcp_tx_request_o(dhcp_tx_request_o), .tx_data_o(tx_data_o), .length_o(length_o),
    .client_mac_o(client_mac_o), .lease_granted_o(lease_granted_o),
    .dhcp_destination_mac_o(dest_mac), .dhcp_destination_ip_o(dest_ip),
    .dhcp_destination_port_o(dest_port)
  );

  logic [7:0] pkt  [0:299];
  logic [7:0] rbuf [0:399];
  logic [7:0] expb [0:299];
  int n_cmp = 0;
  int n_err = 0;
  int lg_count = 0;

  always @(posedge clk) if (lease_granted_o) lg_count++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mtype 01 DISCOVER (len 244) or 03 REQUEST with option 50 = req_ip (len 250)
  task automatic build_pkt(input logic [7:0] op, input logic [7:0] mtype,
                           input logic [31:0] req_ip, output int len);
    logic [31:0] xid;
    logic [47:0] mac;
    xid = 32'h1234_5678;
    mac = 48'h001C_C0A2_13DD;
    for (int i = 0; i < 300; i++) pkt[i] = 8'h00;
    pkt[0] = op; pkt[1] = 8'h01; pkt[2] = 8'h06;
    for (int k = 0; k < 4; k++) pkt[4+k] = xid[31-8*k -: 8];
    for (int k = 0; k < 6; k++) pkt[28+k] = mac[47-8*k -: 8];
    pkt[236] = 8'h63; pkt[237] = 8'h82; pkt[238] = 8'h53; pkt[239] = 8'h63;
    pkt[240] = 8'h35; pkt[241] = 8'h01; pkt[242] = mtype;
    if (mtype == 8'h03) begin
      pkt[243] = 8'h32; pkt[244] = 8'h04;
      for (int k = 0; k < 4; k++) pkt[245+k] = req_ip[31-8*k -: 8];
      pkt[249] = 8'hFF;
      len = 250;
    end else begin
      pkt[243] = 8'hFF;
      len = 244;
    end
  endtask

  task automatic send_pkt(input int len);
    @(negedge clk);
    dhcp_rx_active = 1'b1;
    for (int i = 0; i < len; i++) begin
      rx_enable = 1'b1;
      rx_data   = pkt[i];
      @(negedge clk);
    end
    rx_enable      = 1'b0;
    dhcp_rx_active = 1'b0;
    rx_data        = 8'h00;
  endtask

  // kind: 0 OFFER, 1 ACK, 2 NAK
  task automatic build_exp(input int kind);
    logic [31:0] lease, srv, offer, mask, xid;
    logic [47:0] mac;
    lease = 32'd86400; srv = SERVER_IP; offer = OFFER_IP; mask = MASK;
    xid = 32'h1234_5678; mac = 48'h001C_C0A2_13DD;
    for (int i = 0; i < 300; i++) expb[i] = 8'h00;
    expb[0] = 8'h02; expb[1] = 8'h01; expb[2] = 8'h06; expb[10] = 8'h80;
    for (int k = 0; k < 4; k++) begin
      expb[4+k]   = xid[31-8*k -: 8];
      expb[16+k]  = (kind == 2) ? 8'h00 : offer[31-8*k -: 8];
      expb[20+k]  = srv[31-8*k -: 8];
      expb[245+k] = srv[31-8*k -: 8];
    end
    for (int k = 0; k < 6; k++) expb[28+k] = mac[47-8*k -: 8];
    expb[236] = 8'h63; expb[237] = 8'h82; expb[238] = 8'h53; expb[239] = 8'h63;
    expb[240] = 8'h35; expb[241] = 8'h01;
    expb[242] = (kind == 0) ? 8'h02 : (kind == 1) ? 8'h05 : 8'h06;
    expb[243] = 8'h36; expb[244] = 8'h04;
    if (kind == 2) expb[249] = 8'hFF;
    else begin
      expb[249] = 8'h33; expb[250] = 8'h04;
      for (int k = 0; k < 4; k++) expb[251+k] = lease[31-8*k -: 8];
      expb[255] = 8'h01; expb[256] = 8'h04;
      for (int k = 0; k < 4; k++) expb[257+k] = mask[31-8*k -: 8];
      expb[261] = 8'hFF;
    end
  endtask

  function automatic int seq_errs(input int n, input int exp_len);
    int e;
    e = (n != exp_len) ? 1 : 0;
    for (int i = 0; i < n && i < exp_len; i++) if (rbuf[i] !== expb[i]) e++;
    return e;
  endfunction

  // Waits (bounded) for a request, grants, and collects bytes on active cycles.
  // abort_at >= 0 asserts reset when that many bytes have been consumed.
  task automatic get_reply(input bit stall, input int abort_at,
                           output bit seen, output int n, output logic [15:0] len);
    bit act;
    seen = 1'b0; n = 0; len = '0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (dhcp_tx_request_o) seen = 1'b1;
    end
    if (!seen) return;
    len = length_o;
    udp_tx_enable = 1'b1;
    @(negedge clk);
    udp_tx_enable = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      act = stall ? (c % 2 == 1) : 1'b1;
      if (act && n == abort_at) begin
        udp_tx_active = 1'b0;
        rst_n = 1'b0;
        return;
      end
      udp_tx_active = act;
      if (act) begin
        rbuf[n] = tx_data_o;
        n++;
      end
      @(posedge clk); #1;
      if (!dhcp_tx_request_o) break;
      @(negedge clk);
    end
    udp_tx_active = 1'b0;
  endtask

  initial begin
    bit seen;
    int n, plen, lg0;
    logic [15:0] len;

    rst_n = 1'b0; rx_data = '0; rx_enable = 1'b0; dhcp_rx_active = 1'b0;
    udp_tx_enable = 1'b0; udp_tx_active = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", dhcp_tx_request_o, 0);
    check("rst_txdata", tx_data_o, 0);
    check("rst_length", length_o, 0);
    check("rst_mac", client_mac_o, 0);
    check("rst_lease", lease_granted_o, 0);
    check("dest_mac", dest_mac, 48'hFFFF_FFFF_FFFF);
    check("dest_ip", dest_ip, 32'hFFFF_FFFF);
    check("dest_port", dest_port, 16'd68);
    rst_n = 1'b1;

    // DISCOVER -> OFFER
    lg0 = lg_count;
    build_pkt(8'h01, 8'h01, 32'h0, plen);
    send_pkt(plen);
    get_reply(1'b0, -1, seen, n, len);
    repeat (3) @(negedge clk);
    build_exp(0);
    check("offer_req", seen, 1);
    check("offer_len", len, 16'd262);
    check("offer_cnt", n, 262);
    check("offer_xid", {rbuf[4], rbuf[5], rbuf[6], rbuf[7]}, 32'h1234_5678);
    check("offer_yiaddr", {rbuf[16], rbuf[17], rbuf[18], rbuf[19]}, OFFER_IP);
    check("offer_type", rbuf[242], 8'h02);
    check("offer_end", rbuf[261], 8'hFF);
    check("offer_seq", seq_errs(n, 262), 0);
    check("offer_nolease", lg_count - lg0, 0);

    // REQUEST for offer_ip -> ACK
    lg0 = lg_count;
    build_pkt(8'h01, 8'h03, OFFER_IP, plen);
    send_pkt(plen);
    get_reply(1'b0, -1, seen, n, len);
    repeat (3) @(negedge clk);
    build_exp(1);
    check("ack_req", seen, 1);
    check("ack_len", len, 16'd262);
    check("ack_type", rbuf[242], 8'h05);
    check("ack_lease_opt", {rbuf[249], rbuf[250], rbuf[251], rbuf[252], rbuf[253], rbuf[254]},
          48'h3304_0001_5180);
    check("ack_seq", seq_errs(n, 262), 0);
    check("ack_pulse", lg_count - lg0, 1);
    check("ack_mac", client_mac_o, 48'h001C_C0A2_13DD);

    // REQUEST for another IP -> NAK
    lg0 = lg_count;
    build_pkt(8'h01, 8'h03, OTHER_IP, plen);
    send_pkt(plen);
    get_reply(1'b0, -1, seen, n, len);
    repeat (3) @(negedge clk);
    build_exp(2);
    check("nak_req", seen, 1);
    check("nak_len", len, 16'd250);
    check("nak_cnt", n, 250);
    check("nak_type", rbuf[242], 8'h06);
    check("nak_yiaddr", {rbuf[16], rbuf[17], rbuf[18], rbuf[19]}, 32'h0);
    check("nak_end", rbuf[249], 8'hFF);
    check("nak_seq", seq_errs(n, 250), 0);
    check("nak_nolease", lg_count - lg0, 0);

    // Rejected packets: bad cookie, op 02, truncated to 200 bytes
    for (int k = 0; k < 3; k++) begin
      build_pkt(k == 1 ? 8'h02 : 8'h01, 8'h01, 32'h0, plen);
      if (k == 0) pkt[237] = 8'h00;
      if (k == 2) plen = 200;
      send_pkt(plen);
      get_reply(1'b0, -1, seen, n, len);
      check(k == 0 ? "rej_cookie" : k == 1 ? "rej_op" : "rej_short", seen, 0);
    end

    // 50% stalled OFFER with a second DISCOVER arriving during TX_SEND
    build_pkt(8'h01, 8'h01, 32'h0, plen);
    send_pkt(plen);
    fork
      get_reply(1'b1, -1, seen, n, len);
      begin
        repeat (20) @(negedge clk);
        send_pkt(plen);
      end
    join
    build_exp(0);
    check("stall_req", seen, 1);
    check("stall_seq", seq_errs(n, 262), 0);
    get_reply(1'b0, -1, seen, n, len);
    check("stall_no_second", seen, 0);

    // Reset at byte 100 of an OFFER, then a clean OFFER
    send_pkt(plen);
    get_reply(1'b0, 100, seen, n, len);
    #1;
    check("abort_req", dhcp_tx_request_o, 0);
    check("abort_txdata", tx_data_o, 0);
    check("abort_length", length_o, 0);
    check("abort_mac", client_mac_o, 0);
    check("abort_lease", lease_granted_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_pkt(plen);
    get_reply(1'b0, -1, seen, n, len);
    check("after_req", seen, 1);
    check("after_len", len, 16'd262);
    check("after_seq", seq_errs(n, 262), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dhcp_server.md
# dhcp_server

Minimal single-lease DHCP server, the server side of the board's DHCP exchange, for point-to-point links with no network DHCP server. It parses UDP port-67 payloads from the Ethernet receive path and answers DISCOVER with OFFER and REQUEST with ACK or NAK. Replies are broadcast to port 68 through the shared UDP transmit arbiter using the same request/enable/active handshake as the other UDP sources.

## Interface

- LEASE_TIME, 32'd86400: lease seconds sent in option 51.
- clock  in  1  single clock for receive parse and transmit.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  UDP payload byte.
- rx_enable  in  1  rx_data valid this cycle.
- dhcp_rx_active  in  1  high for the whole payload of a packet to port 67.
- server_ip  in  32  our address, sent in siaddr and option 54.
- offer_ip  in  32  the single address leased out.
- subnet_mask  in  32  sent in option 1.
- udp_tx_enable  in  1  arbiter grant.
- udp_tx_active  in  1  UDP layer consumes tx_data this cycle.
- dhcp_tx_request  out  1  request to the arbiter.
- tx_data  out  8  reply byte.
- length  out  16  reply payload length.
- client_mac  out  48  chaddr of the last client that received an ACK.
- lease_granted  out  1  one-cycle pulse when an ACK finishes sending.
- dhcp_destination_mac  out  48  constant 48'hFFFFFFFFFFFF.
- dhcp_destination_ip  out  32  constant 32'hFFFFFFFF.
- dhcp_destination_port  out  16  constant 16'd68.

## Operation

- Receive byte counter rx_byte_no counts bytes with rx_enable && dhcp_rx_active. The first byte is 0.
- Accept only when the arrived bytes meet all of these:
  - byte 0 = 01, byte 1 = 01, byte 2 = 06;
  - bytes 236–239 = 63 82 53 63;
  - bytes 240–241 = 35 01;
  - byte 242 = 01 (DISCOVER) or 03 (REQUEST).
- A failed check sets a drop flag. The remaining bytes are ignored.
- Capture xid (bytes 4–7) and chaddr (bytes 28–33).
- For REQUEST, check bytes 243–248. If they equal 32 04 followed by offer_ip, the reply is ACK; otherwise it is NAK.
- On the falling edge of dhcp_rx_active, if the packet was not dropped and at least 243 bytes (DISCOVER) or 249 bytes (REQUEST) arrived, latch the reply type (OFFER, ACK or NAK) and go to TX_WAIT. Shorter packets are discarded silently.
- Transmit states are TX_IDLE, TX_WAIT and TX_SEND.
  - TX_WAIT: set length to 262 (OFFER/ACK) or 250 (NAK) and assert dhcp_tx_request. When udp_tx_enable is seen, drive byte 0 (02) and go to TX_SEND with byte_no = 1.
  - TX_SEND: each cycle with udp_tx_active, drive byte byte_no and increment it. When byte_no == length, clear dhcp_tx_request and return to TX_IDLE.
- Reply byte map, by byte index:
  - 0–3 = 02 01 06 00.
  - 4–7 = xid.
  - 8–9 = 00.
  - 10–11 = 80 00 (broadcast flag).
  - 12–15 = 0.
  - 16–19 = offer_ip, or 0 for NAK.
  - 20–23 = server_ip.
  - 24–27 = 0.
  - 28–33 = chaddr.
  - 34–235 = 0.
  - 236–239 = cookie.
  - 240–242 = 35 01 type (02 OFFER, 05 ACK, 06 NAK).
  - 243–248 = 36 04 server_ip.
  - OFFER/ACK: 249–254 = 33 04 LEASE_TIME; 255–260 = 01 04 subnet_mask; 261 = FF.
  - NAK: 249 = FF.
- While the transmit state is not TX_IDLE, received packets are ignored. No queueing.
- On ACK completion, load client_mac with chaddr and pulse lease_granted.

## Timing

- Reset values: dhcp_tx_request 0, tx_data 0, length 0, client_mac 0, lease_granted 0, rx and tx state idle, counters 0, drop flag 0.
- An assertion of reset during TX_SEND aborts the reply. No partial state survives.
- TX_WAIT is entered 1 cycle after the dhcp_rx_active fall. dhcp_tx_request rises on the next cycle.
- tx_data for byte 0 is valid the cycle after the udp_tx_enable sample, before udp_tx_active.
- Every later byte updates 1 cycle after the udp_tx_active sample.
- lease_granted rises in the cycle dhcp_tx_request falls.
- A reply needs exactly length cycles of udp_tx_active.
- A new dhcp_rx_active start in the same cycle as the return to TX_IDLE is parsed.
- Stalls (udp_tx_active low) hold tx_data and byte_no.
- Between packets, dhcp_rx_active low resets rx_byte_no and the drop flag.

## Test plan

- DISCOVER from MAC 00:1C:C0:A2:13:DD, xid 12345678 -> OFFER:
  - length 262;
  - bytes 4–7 = 12 34 56 78;
  - yiaddr = offer_ip;
  - byte 242 = 02, byte 261 = FF.
- REQUEST with 32 04 and offer_ip -> ACK:
  - byte 242 = 05;
  - bytes 249–254 = 33 04 00 01 51 80;
  - lease_granted pulses once;
  - client_mac = 001CC0A213DD.
- REQUEST with a different requested IP -> NAK: length 250, byte 242 = 06, yiaddr 0, byte 249 = FF, no lease_granted.
- Bad cookie (byte 237 = 00), op = 02, or a 200-byte truncated packet -> dhcp_tx_request never asserts.
- udp_tx_active toggled at 50% during an OFFER -> byte sequence identical to the unstalled case. A second DISCOVER during TX_SEND produces no second reply.
- reset asserted at byte 100 of an OFFER -> all outputs at reset values immediately. The next DISCOVER gives a complete, correct OFFER.
